cmdout_writer: RTL and testbench

CMDOUT_WRITER -- requirements
Module: cmdout_writer

---
 rtl/cmdout_writer.sv | 167 ++++++++++++++++
 tb/tb_cmdout_writer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmdout_writer.sv
// -----------------------------------------------------------------------------
// cmdout_writer
// Publishes finished-task notifications into per-accelerator command-out rings
// held in an external 64-bit memory. Each ring is 64 words (32 two-word
// entries). An entry's TID word is written first, and its header word second,
// so a consumer that sees a valid header always sees the matching TID.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready notification handshake
//   in_acc_id, in_tid finishing accelerator and the task id word to publish
//   mem_en/mem_wr     memory enable and byte write enables (0 = read)
//   mem_addr/mem_din  byte address and write data
//   mem_dout          read data, valid one cycle after a read is issued
//   written_cmds      number of entries published (wraps at 2^32)
//   err_acc           sticky: a notification named an out-of-range accelerator
//   stall_cycles      polls that found the target slot still occupied
//
// Build option
//   CMDOUT_WRITER_STALL_CNT_EN  builds the stall_cycles counter; without it
//                               stall_cycles is tied to zero.
// -----------------------------------------------------------------------------
module cmdout_writer #(
    parameter  int unsigned NUM_ACCS = 16,
    localparam int unsigned ACC_BITS = (NUM_ACCS > 1) ? $clog2(NUM_ACCS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ACC_BITS-1:0] in_acc_id,
    input  logic [63:0]         in_tid,
    output logic                mem_en,
    output logic [7:0]          mem_wr,
    output logic [31:0]         mem_addr,
    output logic [63:0]         mem_din,
    input  logic [63:0]         mem_dout,
    output logic [31:0]         written_cmds,
    output logic                err_acc,
    output logic [31:0]         stall_cycles
);

    localparam logic [63:0]       HDR_WORD  = 64'h8000_0000_0000_0001;
    localparam logic [ACC_BITS:0] ACC_LIMIT = (ACC_BITS + 1)'(NUM_ACCS);

    typedef enum logic [2:0] {
        IDLE,
        RD_HDR,
        CHK_HDR,
        WR_TID,
        WR_HDR
    } state_t;

    state_t              r_state;
    logic [ACC_BITS-1:0] r_acc;
    logic [63:0]         r_tid;
    logic [5:0]          r_slot [NUM_ACCS];

    logic [5:0]          w_slot;
    logic [31:0]         w_hdr_addr;
    logic [31:0]         w_tid_addr;
    logic                w_acc_ok;
    logic                w_slot_free;
    logic                w_unused_dout;

    // Current slot of the captured accelerator and the addresses of its entry.
    // Slots are always even, so the TID word sits at the odd word index.
    assign w_slot      = r_slot[r_acc];
    assign w_hdr_addr  = 32'({r_acc, w_slot, 3'b000});
    assign w_tid_addr  = 32'({r_acc, w_slot[5:1], 1'b1, 3'b000});
    assign w_acc_ok    = ({1'b0, in_acc_id} < ACC_LIMIT);
    assign w_slot_free = (mem_dout[63:56] == 8'h00);
    assign w_unused_dout = ^mem_dout[55:0];

    // Ready only in IDLE and forced low while reset is held.
    assign in_ready = (r_state == IDLE) && !rst;

    // Publishing FSM with registered memory-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_tid        <= '0;
            for (int unsigned i = 0; i < NUM_ACCS; i++) begin
                r_slot[i] <= '0;
            end
            written_cmds <= '0;
            err_acc      <= 1'b0;
            mem_en       <= 1'b0;
            mem_wr       <= '0;
            mem_addr     <= '0;
            mem_din      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_acc_ok) begin
                            r_acc    <= in_acc_id;
                            r_tid    <= in_tid;
                            r_state  <= RD_HDR;
                            mem_en   <= 1'b1;
                            mem_wr   <= '0;
                            mem_addr <= 32'({in_acc_id, r_slot[in_acc_id], 3'b000});
                        end else begin
                            err_acc <= 1'b1;
                        end
                    end
                end
                RD_HDR: begin
                    r_state <= CHK_HDR;
                    mem_en  <= 1'b0;
                end
                CHK_HDR: begin
                    mem_en <= 1'b1;
                    if (w_slot_free) begin
                        r_state  <= WR_TID;
                        mem_wr   <= 8'hFF;
                        mem_addr <= w_tid_addr;
                        mem_din  <= r_tid;
                    end else begin
                        // Slot still owned by the consumer: poll the header again.
                        r_state  <= RD_HDR;
                        mem_wr   <= '0;
                        mem_addr <= w_hdr_addr;
                    end
                end
                WR_TID: begin
                    r_state  <= WR_HDR;
                    mem_en   <= 1'b1;
                    mem_wr   <= 8'hFF;
                    mem_addr <= w_hdr_addr;
                    mem_din  <= HDR_WORD;
                end
                WR_HDR: begin
                    r_state       <= IDLE;
                    mem_en        <= 1'b0;
                    mem_wr        <= '0;
                    r_slot[r_acc] <= w_slot + 6'd2;
                    written_cmds  <= written_cmds + 32'd1;
                end
                default: begin
                    r_state <= IDLE;
                    mem_en  <= 1'b0;
                    mem_wr  <= '0;
                end
            endcase
        end
    end

`ifdef CMDOUT_WRITER_STALL_CNT_EN
    logic [31:0] r_stall;

    // One count per header check that finds the slot occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((r_state == CHK_HDR) && !w_slot_free) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cmdout_writer.sv
// -----------------------------------------------------------------------------
// tb_cmdout_writer
// Bench for cmdout_writer (NUM_ACCS = 12). A behavioural memory answers the
// DUT; a transaction-level model predicts, per notification, the header read
// address, the ordered TID/header writes and the final counters. tick() steps
// one cycle and compares the memory bus against that model on every cycle.
// -----------------------------------------------------------------------------
module tb_cmdout_writer;

    localparam int unsigned NUM_ACCS  = 12;
    localparam int unsigned ACC_BITS  = 4;
    localparam int unsigned MEM_WORDS = 1 << (ACC_BITS + 6);
    localparam logic [63:0] HDR       = 64'h8000_0000_0000_0001;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        bit          is_tid;
    } wr_t;

    logic                clk       = 1'b0;
    logic                rst       = 1'b1;
    logic                in_valid  = 1'b0;
    logic                in_ready;
    logic [ACC_BITS-1:0] in_acc_id = '0;
    logic [63:0]         in_tid    = '0;
    logic                mem_en;
    logic [7:0]          mem_wr;
    logic [31:0]         mem_addr;
    logic [63:0]         mem_din;
    logic [63:0]         mem_dout  = '0;
    logic [31:0]         written_cmds;
    logic                err_acc;
    logic [31:0]         stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          slot_m [NUM_ACCS];
    logic [31:0] cnt_m       = '0;
    bit          err_m       = 1'b0;
    logic [31:0] stall_m     = '0;
    wr_t         exp_wq[$];
    logic [31:0] exp_rd_addr = '0;
    bit          exp_rd_valid = 1'b0;
    logic [31:0] last_hdr_m  = '0;
    int          since_hs    = 0;

    // Addresses seen on the bus
    logic [31:0] obs_tid_addr = '0;
    logic [31:0] obs_hdr_addr = '0;

    // Behavioural memory plus a one-shot header-byte poke used as the consumer
    logic [63:0]         mem [MEM_WORDS] = '{default: 64'h0};
    logic [ACC_BITS+5:0] op_idx  = '0;
    logic [7:0]          op_byte = '0;
    int                  op_seq  = 0;
    int                  op_done = 0;

    cmdout_writer #(.NUM_ACCS(NUM_ACCS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_acc_id    (in_acc_id),
        .in_tid       (in_tid),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .written_cmds (written_cmds),
        .err_acc      (err_acc),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (op_seq != op_done) begin
            mem[op_idx][63:56] = op_byte;
            op_done = op_seq;
        end
        if (mem_en) begin
            if (mem_wr == 8'h00) begin
                mem_dout <= mem[mem_addr[ACC_BITS+8:3]];
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_wr[b]) mem[mem_addr[ACC_BITS+8:3]][8*b +: 8] = mem_din[8*b +: 8];
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] addr_of(input int acc, input int slot);
        return (32'(acc) << 9) | (32'(slot) << 3);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[ACC_BITS+8:3]);
    endfunction

    // One cycle; compare the bus against the model.
    task automatic tick();
        wr_t         w;
        logic [31:0] h;
        @(negedge clk);
        since_hs++;
        if (!rst) begin
`ifndef CMDOUT_WRITER_STALL_CNT_EN
            chk("stall_const", 64'(stall_cycles), 64'd0);
`endif
            if (mem_en) begin
                if (mem_wr == 8'h00) begin
                    n_checks++;
                    if (!exp_rd_valid) begin
                        n_fail++;
                        $display("FAIL unexpected_read: got read at %h, expected no access", mem_addr);
                    end else if (mem_addr !== exp_rd_addr) begin
                        n_fail++;
                        $display("FAIL rd_addr: got %h, expected %h", mem_addr, exp_rd_addr);
                    end
                end else if (exp_wq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got write at %h data %h, expected no access", mem_addr, mem_din);
                end else begin
                    w = exp_wq.pop_front();
                    chk("wr_be", 64'(mem_wr), 64'hFF);
                    chk(w.is_tid ? "tid_addr" : "hdr_addr", 64'(mem_addr), 64'(w.addr));
                    chk(w.is_tid ? "tid_data" : "hdr_data", mem_din, w.data);
                    if (w.is_tid) begin
                        h = w.addr - 32'd8;
                        chk("slot_free_at_write", 64'(mem[widx(h)][63:56]), 64'd0);
                        obs_tid_addr = mem_addr;
                    end else begin
                        obs_hdr_addr = mem_addr;
                        exp_rd_valid = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic set_hdr_byte(input logic [31:0] a, input logic [7:0] v);
        op_idx  = a[ACC_BITS+8:3];
        op_byte = v;
        op_seq++;
        tick();
    endtask

    // Handshake one notification and load the model's expectations for it.
    task automatic notify_start(input int acc, input logic [63:0] tid);
        logic [31:0] h;
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_acc_id = ACC_BITS'(acc);
        in_tid    = tid;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got in_ready 0, expected 1");
        end
        if (acc < int'(NUM_ACCS)) begin
            h = addr_of(acc, slot_m[acc]);
            exp_rd_addr  = h;
            exp_rd_valid = 1'b1;
            exp_wq.push_back(wr_t'{addr: h + 32'd8, data: tid, is_tid: 1'b1});
            exp_wq.push_back(wr_t'{addr: h, data: HDR, is_tid: 1'b0});
            last_hdr_m  = h;
            slot_m[acc] = (slot_m[acc] + 2) % 64;
            cnt_m       = cnt_m + 32'd1;
        end else begin
            err_m = 1'b1;
        end
        since_hs = 0;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int lat);
        while (!in_ready && since_hs < 400) tick();
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got in_ready 0 after %0d cycles, expected 1", since_hs);
        end
        lat = since_hs;
        chk("queue_drained", 64'(exp_wq.size()), 64'd0);
        chk("written_cmds", 64'(written_cmds), 64'(cnt_m));
        chk("err_acc", 64'(err_acc), 64'(err_m));
    endtask

    initial begin
        int          lat;
        int          acc;
        logic [63:0] tid;
        logic [31:0] a;

        for (int i = 0; i < int'(NUM_ACCS); i++) slot_m[i] = 0;

        // Reset values
        repeat (3) tick();
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_din", mem_din, 64'd0);
        chk("rst_written", 64'(written_cmds), 64'd0);
        chk("rst_err", 64'(err_acc), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_release", 64'(in_ready), 64'd1);

        // Single entry to acc 3 in empty memory
        tid = 64'h0000_0005_0000_0001;
        notify_start(3, tid);
        chk("model_pin_tid_addr", 64'(exp_wq[0].addr), 64'h608);
        wait_idle(lat);
        chk("latency_first", 64'(lat), 64'd5);
        chk("first_tid_addr", 64'(obs_tid_addr), 64'h608);
        chk("first_hdr_addr", 64'(obs_hdr_addr), 64'h600);
        a = 32'h608;
        chk("mem_tid_word", mem[widx(a)], tid);
        a = 32'h600;
        chk("mem_hdr_word", mem[widx(a)], 64'h8000_0000_0000_0001);
        chk("written_one", 64'(written_cmds), 64'd1);
        set_hdr_byte(32'h600, 8'h00);

        // Ring wrap on acc 0
        for (int k = 1; k <= 33; k++) begin
            notify_start(0, {$urandom, $urandom});
            wait_idle(lat);
            chk("latency_ring", 64'(lat), 64'd5);
            set_hdr_byte(last_hdr_m, 8'h00);
            if (k == 32) begin
                chk("ring32_hdr", 64'(obs_hdr_addr), 64'h1F0);
                chk("ring32_tid", 64'(obs_tid_addr), 64'h1F8);
            end
            if (k == 33) begin
                chk("ring33_hdr", 64'(obs_hdr_addr), 64'h000);
                chk("ring33_tid", 64'(obs_tid_addr), 64'h008);
            end
        end

        // Occupied slot on acc 1, freed by the consumer later
        set_hdr_byte(32'h200, 8'h80);
        notify_start(1, 64'hDEAD_BEEF_0000_0011);
        while (since_hs < 10) begin
            chk("ready_low_stall", 64'(in_ready), 64'd0);
            tick();
        end
        chk("ready_low_stall", 64'(in_ready), 64'd0);
        op_idx  = 32'h200 >> 3;
        op_byte = 8'h00;
        op_seq++;
        wait_idle(lat);
        chk("latency_stall", 64'(lat), 64'd15);
        chk("stall_hdr_addr", 64'(obs_hdr_addr), 64'h200);
`ifdef CMDOUT_WRITER_STALL_CNT_EN
        stall_m = stall_m + 32'd5;
        chk("stall_cycles", 64'(stall_cycles), 64'(stall_m));
`endif
        set_hdr_byte(32'h200, 8'h00);

        // Out-of-range accelerator id
        notify_start(12, 64'h1234);
        wait_idle(lat);
        chk("err_latency", 64'(lat), 64'd1);
        chk("err_set", 64'(err_acc), 64'd1);
        chk("err_written_same", 64'(written_cmds), 64'd35);
        notify_start(2, 64'h5678);
        wait_idle(lat);
        chk("err_sticky", 64'(err_acc), 64'd1);
        set_hdr_byte(last_hdr_m, 8'h00);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            acc = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) tick();
            notify_start(acc, {$urandom, $urandom});
            wait_idle(lat);
            if (acc < int'(NUM_ACCS)) begin
                chk("latency_rand", 64'(lat), 64'd5);
                set_hdr_byte(last_hdr_m, 8'h00);
            end
        end

        // Reset while the TID word is on the bus
        notify_start(5, 64'hAAAA_0000_0000_0005);
        a = last_hdr_m;
        while (since_hs < 3) tick();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mid_ready", 64'(in_ready), 64'd0);
        chk("rst_mid_written", 64'(written_cmds), 64'd0);
        for (int i = 0; i < int'(NUM_ACCS); i++) slot_m[i] = 0;
        cnt_m   = '0;
        err_m   = 1'b0;
        stall_m = '0;
        exp_wq.delete();
        exp_rd_valid = 1'b0;
        tick();
        tick();
        #1;
        rst = 1'b0;
        tick();
        tick();
        chk("hdr_never_written", 64'(mem[widx(a)][63:56]), 64'd0);
        chk("err_cleared", 64'(err_acc), 64'd0);
        notify_start(5, 64'hBBBB_0000_0000_0005);
        chk("model_pin_slot0", 64'(exp_rd_addr), 64'hA00);
        wait_idle(lat);
        chk("latency_after_rst", 64'(lat), 64'd5);
        chk("after_rst_hdr", 64'(obs_hdr_addr), 64'hA00);
        chk("after_rst_tid", 64'(obs_tid_addr), 64'hA08);
        chk("after_rst_written", 64'(written_cmds), 64'd1);
        chk("final_stall", 64'(stall_cycles), 64'(stall_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
